// File: rtl/board_store_if.sv
// Write bus between the game-logic FSM (master) and the board store (slave).
interface board_store_if;
    logic       board_change_en;
    logic [4:0] board_in_addr;
    logic [4:0] board_in_piece;
    logic       ready;

    modport master (
        output board_change_en,
        output board_in_addr,
        output board_in_piece,
        input  ready
    );

    modport slave (
        input  board_change_en,
        input  board_in_addr,
        input  board_in_piece,
        output ready
    );
endinterface

// File: rtl/board_store.sv
// Board register file for the 4x8 dark-chess board: single-square writes with
// capture accounting, plus new-game load and LFSR-driven Fisher-Yates shuffle.
module board_store #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic           CLK,
    input  logic           RESET,
    input  logic           new_game,
    board_store_if.slave   bus,
    output logic [159:0]   board_output,
    output logic [4:0]     red_count,
    output logic [4:0]     black_count,
    output logic           game_over,
    output logic           winner
);

    // An all-zero Galois LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] Taps    = 16'hB400;

    typedef enum logic [1:0] {StIdle, StLoad, StShuffle} state_t;

    state_t      state_q, state_d;
    logic [4:0]  board_q [32];
    logic [4:0]  board_d [32];
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  red_q, red_d;
    logic [4:0]  black_q, black_d;
    logic [4:0]  j;
    logic [4:0]  target;

    // Canonical covered piece for square sq: colour = sq[4], type from sq[3:0].
    function automatic logic [4:0] canon(input logic [4:0] sq);
        logic [3:0] k;
        logic [4:0] h;
        logic [2:0] t;
        k = sq[3:0];
        h = (({1'b0, k} + 5'd1) >> 1) - 5'd1;
        t = (k < 4'd5) ? 3'd1 : h[2:0];
        return {sq[4], t, 1'b0};
    endfunction

    assign j      = lfsr_q[4:0];
    assign target = board_q[bus.board_in_addr];

    // LFSR advances every cycle regardless of state so new_game timing seeds the shuffle.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ Taps;
        end
    end

    // Next-state: FSM, board contents, shuffle index and surviving-piece counts.
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        idx_d   = idx_q;
        red_d   = red_q;
        black_d = black_q;
        unique case (state_q)
            StIdle: begin
                if (new_game) begin
                    // new_game wins; a same-cycle write is dropped.
                    state_d = StLoad;
                end else if (bus.board_change_en) begin
                    board_d[bus.board_in_addr] = bus.board_in_piece;
                    if (bus.board_in_piece[3:1] != 3'b000 && target[3:1] != 3'b000) begin
                        if (target[4]) begin
                            black_d = (black_q == 5'd0) ? 5'd0 : black_q - 5'd1;
                        end else begin
                            red_d = (red_q == 5'd0) ? 5'd0 : red_q - 5'd1;
                        end
                    end
                end
            end
            StLoad: begin
                for (int i = 0; i < 32; i++) begin
                    board_d[i] = canon(5'(i));
                end
                red_d   = 5'd16;
                black_d = 5'd16;
                idx_d   = 5'd31;
                state_d = StShuffle;
            end
            StShuffle: begin
                // Rejection sampling: only j <= idx keeps the permutation uniform.
                if (j <= idx_q) begin
                    board_d[idx_q] = board_q[j];
                    board_d[j]     = board_q[idx_q];
                    idx_d          = idx_q - 5'd1;
                    if (idx_q == 5'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; async reset restores the canonical, unshuffled board.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            lfsr_q  <= SeedEff;
            idx_q   <= 5'd31;
            red_q   <= 5'd16;
            black_q <= 5'd16;
            for (int i = 0; i < 32; i++) begin
                board_q[i] <= canon(5'(i));
            end
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            red_q   <= red_d;
            black_q <= black_d;
            for (int i = 0; i < 32; i++) begin
                board_q[i] <= board_d[i];
            end
        end
    end

    // Flatten the square array onto the output bus.
    always_comb begin
        board_output = '0;
        for (int i = 0; i < 32; i++) begin
            board_output[5*i +: 5] = board_q[i];
        end
    end

    assign bus.ready   = (state_q == StIdle);
    assign red_count   = red_q;
    assign black_count = black_q;
    assign game_over   = (red_q == 5'd0) || (black_q == 5'd0);
    assign winner      = (red_q == 5'd0);

endmodule

// File: doc/board_store.md
# board_store

Board register file and game initialiser for the 4x8 dark-chess board. It is the write-responder for the game-logic FSM. It holds the 32 five-bit squares and presents them flattened as `board_output`. It accepts single-square write requests on `board_change_en`/`board_in_addr`/`board_in_piece`. On `new_game` it loads the full piece set face-down and shuffles it with an on-chip LFSR. It also tracks surviving pieces per colour and flags game over.

## Interface
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `CLK` input, 1 bit: system clock, all state on rising edge.
- `RESET` input, 1 bit: asynchronous, active-high reset.
- `new_game` input, 1 bit: single-cycle pulse, starts load+shuffle.
- `board_change_en` input, 1 bit: write strobe, one square per asserted cycle.
- `board_in_addr` input, 5 bits: target square {row[4:3], col[2:0]}.
- `board_in_piece` input, 5 bits: {colour, type[2:0], uncovered}.
- `board_output` output, 160 bits: square i occupies bits [5i+4:5i].
- `ready` output, 1 bit: 1 when in IDLE, so writes are accepted.
- `red_count` output, 5 bits: surviving red pieces, 0..16.
- `black_count` output, 5 bits: surviving black pieces, 0..16.
- `game_over` output, 1 bit: high when either count is 0.
- `winner` output, 1 bit: colour with nonzero count. Valid only when `game_over` is high.

## Operation
- **Canonical layout, square i:**
  - colour = i[4].
  - type by i[3:0]: 0-4 soldier (001), 5-6 cannon (010), 7-8 knight (011), 9-10 rook (100), 11-12 bishop (101), 13-14 queen (110), 15 king (111).
  - uncovered = 0.
- **LFSR:** 16-bit Galois, taps mask 16'hB400. It shifts every cycle in every state, so `new_game` timing seeds the shuffle.
- **FSM states:** IDLE, LOAD, SHUFFLE.
- **IDLE**
  - `ready`=1.
  - `new_game` -> LOAD. It takes priority over a same-cycle write; that write is dropped.
  - An accepted write stores `board_in_piece` at `board_in_addr`.
- **LOAD** (1 cycle)
  - Write the canonical layout to all 32 squares.
  - counts <= 16 each; idx <= 31.
  - -> SHUFFLE.
- **SHUFFLE** (Fisher-Yates with rejection)
  - Each cycle let j = lfsr[4:0].
  - If j <= idx: swap square[idx] and square[j] (j == idx is a no-op swap), then idx <= idx-1.
  - Otherwise: no change; retry on the next LFSR value.
  - When a swap is performed with idx == 1 -> IDLE.
- `new_game` and writes are ignored in LOAD and SHUFFLE.
- **Capture accounting**, on an accepted write only:
  - Condition: `board_in_piece[3:1]` != 000 and the current target square type != 000.
  - Action: decrement the count of the target square's stored colour, saturating at 0.
  - Writing an empty piece (5'b00000) never changes the counts.
- `game_over` = (`red_count`==0) | (`black_count`==0).
- `winner` = (`red_count`==0) ? 1 (black) : 0 (red).

## Timing
- **Reset values:**
  - `board_output` = canonical layout.
  - FSM = IDLE, `ready`=1.
  - `red_count`=`black_count`=16, `game_over`=0, `winner`=0.
  - LFSR = seed, idx = 31.
- **Write latency:** a write strobed at edge N is visible on `board_output` and the counts after edge N. There is no backpressure; `ready` is informational only.
- **`new_game` at edge N:** LOAD is at N+1 and the first SHUFFLE cycle is at N+2. `ready` is 0 from after N until the final swap.
- **Shuffle length:**
  - Minimum 31 SHUFFLE cycles.
  - Variable beyond that; a maximal LFSR guarantees termination.
- **Async RESET mid-shuffle:** returns immediately to the reset values, giving a canonical (unshuffled) board.
- **Outputs:** all outputs are registered or decoded directly from registers; there are no combinational paths from inputs.

## Test plan
- **Reset:** assert RESET async mid-cycle -> `board_output` square 0 = 5'b0_001_0, square 15 = 5'b0_111_0, square 31 = 5'b1_111_0; `ready`=1; counts 16/16.
- **Shuffle:** pulse `new_game` -> `ready` falls next edge and rises after >=32 cycles. The final board must hold exactly these covered pieces:
  - per colour: 5 soldiers, 2 each of types 010-110, 1 king;
  - 16 red, 16 black, all bit0=0;
  - the board differs from canonical for seed 16'hACE1.
- **Capture:** after shuffle, write {0,110,1} to a square holding black, then 5'b00000 to the source -> `black_count`=15 and `red_count`=16 one cycle after the first write; the second write leaves counts unchanged.
- **Ignored writes:** strobe writes during SHUFFLE and the same cycle as `new_game` -> no square changes beyond the shuffle permutation; counts remain 16.
- **Game over:** 16 successive capture writes onto red squares -> `red_count` steps 16..0, `game_over`=1, `winner`=1. A further capture write onto an empty square leaves `red_count`=0 with no underflow.
- **Reset mid-shuffle:** assert RESET 10 cycles into SHUFFLE -> canonical board, `ready`=1. A subsequent `new_game` completes normally.
